// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan-capture slice.
//   - Active-high glyph codes (bit0=a ... bit6=g).
//   - N_DIGITS: number of multiplexed digit positions.
//   - Decode-result encoding: 2-bit kind plus 4-bit digit.
//   - digits_to_value: folds four decimal digits into a 14-bit binary value.
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int N_DIGITS = 4;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_R     = 7'h50;

    typedef enum logic [1:0] {
        KIND_DIGIT   = 2'd0,
        KIND_ERR     = 2'd1,
        KIND_ILLEGAL = 2'd2
    } glyph_kind_e;

    typedef struct packed {
        glyph_kind_e kind;
        logic [3:0]  digit;
    } glyph_dec_t;

    // Horner evaluation; the largest result (9999) fits in 14 bits.
    function automatic logic [13:0] digits_to_value(input logic [3:0] d3,
                                                    input logic [3:0] d2,
                                                    input logic [3:0] d1,
                                                    input logic [3:0] d0);
        logic [13:0] acc;
        acc = {10'd0, d3};
        acc = acc * 14'd10 + {10'd0, d2};
        acc = acc * 14'd10 + {10'd0, d1};
        acc = acc * 14'd10 + {10'd0, d0};
        return acc;
    endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_capture_if
// Display bus seen by the capture block.
//   seg_in[6:0]   segment lines (bit0=a ... bit6=g), raw polarity
//   an_in[3:0]    digit enables (bit0=ones ... bit3=thousands), raw polarity
//   value[13:0]   last decoded frame value
//   frame_valid   one-cycle pulse when frame outputs update
//   err_flag      last frame contained E or r
//   glyph_err     last frame contained an undecodable glyph
//   stale         no frame completed within the timeout
// master = display side / bench, slave = capture block.
// ---------------------------------------------------------------------------
interface seg7_scan_capture_if;

    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [13:0] value;
    logic        frame_valid;
    logic        err_flag;
    logic        glyph_err;
    logic        stale;

    modport master (
        output seg_in, an_in,
        input  value, frame_valid, err_flag, glyph_err, stale
    );

    modport slave (
        input  seg_in, an_in,
        output value, frame_valid, err_flag, glyph_err, stale
    );

endinterface

// File: rtl/seg7_glyph_decode.sv
// ---------------------------------------------------------------------------
// seg7_glyph_decode
// Combinational glyph classifier.
//   i_glyph[6:0]  active-high segment pattern (gfedcba)
//   o_dec         {kind, digit}; blank decodes as digit 0, E/r as KIND_ERR,
//                 anything else unknown as KIND_ILLEGAL (digit 0)
// ---------------------------------------------------------------------------
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_glyph,
    output glyph_dec_t o_dec
);

    always_comb begin
        o_dec.kind  = KIND_ILLEGAL;
        o_dec.digit = 4'd0;
        case (i_glyph)
            GLYPH_0, GLYPH_BLANK: begin o_dec.kind = KIND_DIGIT; o_dec.digit = 4'd0; end
            GLYPH_1:              begin o_dec.kind = KIND_DIGIT; o_dec.digit = 4'd1; end
            GLYPH_2:              begin o_dec.kind = KIND_DIGIT; o_dec.digit = 4'd2; end
            GLYPH_3:              begin o_dec.kind = KIND_DIGIT; o_dec.digit = 4'd3; end
            GLYPH_4:              begin o_dec.kind = KIND_DIGIT; o_dec.digit = 4'd4; end
            GLYPH_5:              begin o_dec.kind = KIND_DIGIT; o_dec.digit = 4'd5; end
            GLYPH_6:              begin o_dec.kind = KIND_DIGIT; o_dec.digit = 4'd6; end
            GLYPH_7:              begin o_dec.kind = KIND_DIGIT; o_dec.digit = 4'd7; end
            GLYPH_8:              begin o_dec.kind = KIND_DIGIT; o_dec.digit = 4'd8; end
            GLYPH_9:              begin o_dec.kind = KIND_DIGIT; o_dec.digit = 4'd9; end
            GLYPH_E, GLYPH_R:     begin o_dec.kind = KIND_ERR;   o_dec.digit = 4'd0; end
            default:              begin o_dec.kind = KIND_ILLEGAL; o_dec.digit = 4'd0; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// ---------------------------------------------------------------------------
// seg7_scan_capture
// Samples a multiplexed 7-segment display bus, accepts each digit once it
// has been stable for SETTLE_CYCLES samples, and reassembles 4-digit frames.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_capture_if.slave (seg_in/an_in in; value, frame_valid,
//          err_flag, glyph_err, stale out)
// ---------------------------------------------------------------------------
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_capture_if.slave bus
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [6:0]          r_seg;
    logic [3:0]          r_an;
    logic [10:0]         r_prev;
    logic [CNT_W-1:0]    r_cnt;
    logic [N_DIGITS-1:0] r_seen;
    glyph_dec_t          r_slot [N_DIGITS];
    logic [13:0]         r_value;
    logic                r_frame_valid;
    logic                r_err_flag;
    logic                r_glyph_err;
    logic                r_stale;
    logic [TMO_W-1:0]    r_tcnt;

    logic [10:0]         w_cur;
    logic                w_same;
    logic [3:0]          w_prev_an;
    logic [6:0]          w_prev_seg;
    logic                w_accept;
    logic                w_complete;
    glyph_dec_t          w_dec;
    logic                w_any_err;
    logic                w_any_ill;
    logic [13:0]         w_sum;

    // Register the bus once and normalise both fields to active-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= '0;
            r_an  <= '0;
        end else begin
            r_seg <= (SEG_ACTIVE_LOW != 0) ? ~bus.seg_in : bus.seg_in;
            r_an  <= (AN_ACTIVE_LOW  != 0) ? ~bus.an_in  : bus.an_in;
        end
    end

    assign w_cur      = {r_an, r_seg};
    assign w_same     = (w_cur == r_prev);
    assign w_prev_an  = r_prev[10:7];
    assign w_prev_seg = r_prev[6:0];

    // When the counter shows SETTLE_CYCLES-1, r_prev holds the sample that
    // has been stable for SETTLE_CYCLES cycles, so that is what gets accepted
    // even if the live sample has just moved on. Saturation makes it one-shot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_prev <= w_cur;
            if (!w_same)
                r_cnt <= '0;
            else if (r_cnt != CNT_W'(SETTLE_CYCLES))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_accept   = (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) && $onehot(w_prev_an);
    assign w_complete = &r_seen;

    seg7_glyph_decode u_decode (
        .i_glyph (w_prev_seg),
        .o_dec   (w_dec)
    );

    // Slots hold decoded results; an accept during the completion cycle lands
    // in the freshly cleared seen mask so it belongs to the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen <= '0;
            for (int i = 0; i < N_DIGITS; i++)
                r_slot[i] <= '0;
        end else begin
            r_seen <= (w_complete ? '0 : r_seen) | (w_accept ? w_prev_an : '0);
            for (int i = 0; i < N_DIGITS; i++)
                if (w_accept && w_prev_an[i])
                    r_slot[i] <= w_dec;
        end
    end

    always_comb begin
        w_any_err = 1'b0;
        w_any_ill = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_slot[i].kind == KIND_ERR)     w_any_err = 1'b1;
            if (r_slot[i].kind == KIND_ILLEGAL) w_any_ill = 1'b1;
        end
    end

    assign w_sum = digits_to_value(r_slot[3].digit, r_slot[2].digit,
                                   r_slot[1].digit, r_slot[0].digit);

    // Frame outputs: error glyphs outrank illegal glyphs, either forces 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_valid <= 1'b0;
            r_value       <= '0;
            r_err_flag    <= 1'b0;
            r_glyph_err   <= 1'b0;
        end else begin
            r_frame_valid <= w_complete;
            if (w_complete) begin
                r_err_flag  <= w_any_err;
                r_glyph_err <= !w_any_err && w_any_ill;
                r_value     <= (w_any_err || w_any_ill) ? 14'd0 : w_sum;
            end
        end
    end

    // Timeout watchdog; keyed off w_complete so stale drops together with
    // the frame_valid rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt  <= '0;
            r_stale <= 1'b0;
        end else if (w_complete) begin
            r_tcnt  <= '0;
            r_stale <= 1'b0;
        end else if (r_tcnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_stale <= 1'b1;
        end else begin
            r_tcnt <= r_tcnt + TMO_W'(1);
        end
    end

    assign bus.value       = r_value;
    assign bus.frame_valid = r_frame_valid;
    assign bus.err_flag    = r_err_flag;
    assign bus.glyph_err   = r_glyph_err;
    assign bus.stale       = r_stale;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_capture
// Self-checking bench for seg7_scan_capture: table-driven frames, random
// frames against a decimal reference model, and multi-cycle corner cases
// (short holds, toggling, timeout, reset mid-frame).
// ---------------------------------------------------------------------------
module tb_seg7_scan_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 50;

    localparam logic [6:0] DIGIT_GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        string           name;
        logic [3:0][6:0] glyphs;
        int              expValue;
        bit              expErr;
        bit              expGerr;
    } vecT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_capture_if busIf();

    seg7_scan_capture #(
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    int assertCount = 0;
    int failCount   = 0;
    int fvCount     = 0;
    int fvValue     = 0;
    bit fvErr       = 1'b0;
    bit fvGerr      = 1'b0;
    bit fvStale     = 1'b0;
    bit fvStalePrev = 1'b0;
    bit staleLast   = 1'b0;

    // Frame scoreboard capture, sampled on the falling edge.
    always @(negedge clk) begin
        if (busIf.frame_valid) begin
            fvCount     = fvCount + 1;
            fvValue     = int'(busIf.value);
            fvErr       = busIf.err_flag;
            fvGerr      = busIf.glyph_err;
            fvStale     = busIf.stale;
            fvStalePrev = staleLast;
        end
        staleLast = busIf.stale;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    // Drives one glyph on one-hot position anHot (active-high view) for n cycles.
    task automatic applyStimulus(input logic [6:0] glyph, input logic [3:0] anHot, input int cycles);
        busIf.seg_in = ~glyph;
        busIf.an_in  = ~anHot;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic scanFrame(input logic [3:0][6:0] g, input bit randHold);
        int hold;
        for (int p = 3; p >= 0; p--) begin
            hold = randHold ? int'($urandom_range(4, 9)) : 8;
            applyStimulus(g[p], 4'(1 << p), hold);
        end
        applyStimulus(7'h00, 4'h0, 10);
    endtask

    // Meaning of a glyph: 0..9 for a digit, -2 for E/r, -1 for anything else.
    function automatic int glyphValue(input logic [6:0] g);
        if (g == 7'h00) return 0;
        if (g == 7'h79 || g == 7'h50) return -2;
        for (int i = 0; i < 10; i++)
            if (DIGIT_GLYPH[i] == g) return i;
        return -1;
    endfunction

    task automatic modelFrame(input logic [3:0][6:0] g, output int val, output bit err, output bit gerr);
        int weight;
        int d;
        weight = 1;
        val    = 0;
        err    = 1'b0;
        gerr   = 1'b0;
        for (int p = 0; p < 4; p++) begin
            d = glyphValue(g[p]);
            if (d == -2)      err  = 1'b1;
            else if (d == -1) gerr = 1'b1;
            else              val  = val + d * weight;
            weight = weight * 10;
        end
        if (err) gerr = 1'b0;
        if (err || gerr) val = 0;
    endtask

    task automatic checkFrame(input string tag, input int startCount, input int expVal,
                              input bit expErr, input bit expGerr);
        checkOutput({tag, " frame count"}, fvCount - startCount, 1);
        checkOutput({tag, " value"}, fvValue, expVal);
        checkOutput({tag, " err_flag"}, int'(fvErr), int'(expErr));
        checkOutput({tag, " glyph_err"}, int'(fvGerr), int'(expGerr));
        checkOutput({tag, " stale at frame"}, int'(fvStale), 0);
    endtask

    initial begin
        vecT             vecs [6];
        logic [3:0][6:0] g;
        int              start;
        int              staleCycle;
        int              mVal;
        bit              mErr;
        bit              mGerr;
        int              r;

        vecs[0] = '{"1234",          {7'h06, 7'h5B, 7'h4F, 7'h66}, 1234, 1'b0, 1'b0};
        vecs[1] = '{"blank0007",     {7'h00, 7'h00, 7'h3F, 7'h07},    7, 1'b0, 1'b0};
        vecs[2] = '{"9999",          {7'h6F, 7'h6F, 7'h6F, 7'h6F}, 9999, 1'b0, 1'b0};
        vecs[3] = '{"Errblank",      {7'h79, 7'h50, 7'h50, 7'h00},    0, 1'b1, 1'b0};
        vecs[4] = '{"illegal",       {7'h06, 7'h01, 7'h4F, 7'h66},    0, 1'b0, 1'b1};
        vecs[5] = '{"errOverIllegal",{7'h79, 7'h01, 7'h5B, 7'h4F},    0, 1'b1, 1'b0};

        // Reset state
        busIf.seg_in = 7'h7F;
        busIf.an_in  = 4'hF;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset value", int'(busIf.value), 0);
        checkOutput("reset frame_valid", int'(busIf.frame_valid), 0);
        checkOutput("reset err_flag", int'(busIf.err_flag), 0);
        checkOutput("reset glyph_err", int'(busIf.glyph_err), 0);
        checkOutput("reset stale", int'(busIf.stale), 0);
        rst_n = 1'b1;

        // Timeout from reset with an idle bus
        staleCycle = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (busIf.stale) begin
                staleCycle = c;
                break;
            end
        end
        checkOutput("stale rise cycle", staleCycle, TIMEOUT);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            start = fvCount;
            scanFrame(vecs[v].glyphs, 1'b0);
            checkFrame(vecs[v].name, start, vecs[v].expValue, vecs[v].expErr, vecs[v].expGerr);
            if (v == 0)
                checkOutput("stale before first frame", int'(fvStalePrev), 1);
        end

        // Random frames against the reference model
        for (int n = 0; n < 24; n++) begin
            for (int p = 0; p < 4; p++) begin
                r = int'($urandom_range(0, 19));
                if (r < 10)       g[p] = DIGIT_GLYPH[r];
                else if (r == 10) g[p] = 7'h00;
                else if (r == 11) g[p] = 7'h79;
                else if (r == 12) g[p] = 7'h50;
                else if (r == 13) g[p] = 7'($urandom_range(0, 127));
                else              g[p] = DIGIT_GLYPH[r - 10];
            end
            modelFrame(g, mVal, mErr, mGerr);
            start = fvCount;
            scanFrame(g, 1'b1);
            checkFrame("random", start, mVal, mErr, mGerr);
        end

        // Holds one cycle too short must never be accepted
        start = fvCount;
        for (int p = 3; p >= 0; p--)
            applyStimulus(DIGIT_GLYPH[p + 1], 4'(1 << p), SETTLE - 1);
        applyStimulus(7'h00, 4'h0, 10);
        checkOutput("short holds frame count", fvCount - start, 0);

        // Toggling bus then one stable hold: only the hold is accepted
        start = fvCount;
        for (int i = 0; i < 10; i++)
            applyStimulus(DIGIT_GLYPH[1 + (i % 2)], (i % 2 == 1) ? 4'b0001 : 4'b0010, 1);
        applyStimulus(DIGIT_GLYPH[5], 4'b1000, 5);
        applyStimulus(7'h00, 4'h0, 10);
        checkOutput("toggle no early frame", fvCount - start, 0);
        applyStimulus(DIGIT_GLYPH[6], 4'b0100, 8);
        applyStimulus(DIGIT_GLYPH[7], 4'b0010, 8);
        applyStimulus(DIGIT_GLYPH[8], 4'b0001, 8);
        applyStimulus(7'h00, 4'h0, 10);
        checkFrame("toggle then hold", start, 5678, 1'b0, 1'b0);

        // Reset after two accepted digits discards them
        applyStimulus(DIGIT_GLYPH[1], 4'b0010, 8);
        applyStimulus(DIGIT_GLYPH[2], 4'b0001, 8);
        applyStimulus(7'h00, 4'h0, 1);
        rst_n = 1'b0;
        applyStimulus(7'h00, 4'h0, 2);
        checkOutput("value in mid-frame reset", int'(busIf.value), 0);
        rst_n = 1'b1;
        applyStimulus(7'h00, 4'h0, 2);
        start = fvCount;
        g = {DIGIT_GLYPH[5], DIGIT_GLYPH[6], DIGIT_GLYPH[7], DIGIT_GLYPH[8]};
        scanFrame(g, 1'b0);
        checkFrame("after reset", start, 5678, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
